// File: rtl/sar_sequencer.sv
// sar_sequencer
//
// Conversion sequencer for the SAR ADC macro. It walks the converter through
// INIT -> SAMP -> {COMP -> UPDATE} x n -> DONE, drives the phase strobes that
// feed clkgate, collects one comparator decision per bit (MSB first), and
// publishes the finished word through a valid/ready handshake with a sticky
// overrun flag.
//
// Ports
//   clk, rst_b          clock (rising edge) and asynchronous active-low reset
//   start               request one conversion (level-sampled in IDLE)
//   cont_mode           restart automatically after DONE / leave IDLE by itself
//   abort               abandon the conversion in progress
//   cfg_samp_cycles     SAMP phase length (0 behaves as 1)
//   cfg_nbits           bits per conversion (0 or > NBITS behaves as NBITS)
//   comp_in             comparator decision for the bit being resolved
//   seq_init/samp/comp/update   registered phase strobes for clkgate
//   busy                high whenever the sequencer is not idle
//   result, result_valid, result_ready   result word and its handshake
//   overrun, overrun_clr                 sticky overwrite flag and its clear

module sar_sequencer #(
    parameter int NBITS  = 16,
    parameter int CNT_W  = 8,
    parameter int BIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              cont_mode,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_samp_cycles,
    input  logic [BIDX_W-1:0] cfg_nbits,
    input  logic              comp_in,
    output logic              seq_init,
    output logic              seq_samp,
    output logic              seq_comp,
    output logic              seq_update,
    output logic              busy,
    output logic [NBITS-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [BIDX_W-1:0] NBITS_B = BIDX_W'(NBITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SAMP,
        ST_COMP,
        ST_UPDATE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   sampCfg_q, sampCfg_d;
    logic [BIDX_W-1:0]  nbCfg_q, nbCfg_d;
    logic [CNT_W-1:0]   sampCnt_q, sampCnt_d;
    logic [IDX_W-1:0]   bitIdx_q, bitIdx_d;
    logic [BIDX_W-1:0]  bitsLeft_q, bitsLeft_d;
    logic [NBITS-1:0]   word_q, word_d;
    logic [NBITS-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               seqInit_q, seqSamp_q, seqComp_q, seqUpdate_q, busy_q;
    logic               publish;

    // Next-state logic for the sequencer, the latched configuration, the
    // sample counter, the bit walker and the result handshake.
    always_comb begin
        state_d    = state_q;
        sampCfg_d  = sampCfg_q;
        nbCfg_d    = nbCfg_q;
        sampCnt_d  = sampCnt_q;
        bitIdx_d   = bitIdx_q;
        bitsLeft_d = bitsLeft_q;
        word_d     = word_q;
        result_d   = result_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        publish    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort held high in IDLE blocks a new start.
                if (!abort && (start || cont_mode)) begin
                    state_d   = ST_INIT;
                    sampCfg_d = (cfg_samp_cycles == '0) ? CNT_W'(1) : cfg_samp_cycles;
                    nbCfg_d   = (cfg_nbits == '0 || cfg_nbits > NBITS_B) ? NBITS_B : cfg_nbits;
                end
            end
            ST_INIT: begin
                word_d     = '0;
                bitIdx_d   = IDX_W'(NBITS - 1);
                bitsLeft_d = nbCfg_q;
                // The counter runs S-1 down to 0, giving exactly S SAMP cycles.
                sampCnt_d  = sampCfg_q - CNT_W'(1);
                state_d    = ST_SAMP;
            end
            ST_SAMP: begin
                if (sampCnt_q == '0) begin
                    state_d = ST_COMP;
                end else begin
                    sampCnt_d = sampCnt_q - CNT_W'(1);
                end
            end
            ST_COMP: begin
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                word_d[bitIdx_q] = comp_in;
                bitIdx_d         = bitIdx_q - IDX_W'(1);
                bitsLeft_d       = bitsLeft_q - BIDX_W'(1);
                state_d          = (bitsLeft_q == BIDX_W'(1)) ? ST_DONE : ST_COMP;
            end
            ST_DONE: begin
                publish = 1'b1;
                state_d = cont_mode ? ST_INIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // abort beats both publishing and the continuous-mode restart.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            publish = 1'b0;
        end

        if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        // A publish re-asserts valid even if the old word was consumed on the
        // same edge; overrun only when the old word was still unconsumed.
        if (publish) begin
            result_d = word_q;
            valid_d  = 1'b1;
            if (valid_q && !result_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers. The strobes and busy are decoded from the
    // next state so they are clean flop outputs aligned with the state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            sampCfg_q   <= '0;
            nbCfg_q     <= '0;
            sampCnt_q   <= '0;
            bitIdx_q    <= '0;
            bitsLeft_q  <= '0;
            word_q      <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            seqInit_q   <= 1'b0;
            seqSamp_q   <= 1'b0;
            seqComp_q   <= 1'b0;
            seqUpdate_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sampCfg_q   <= sampCfg_d;
            nbCfg_q     <= nbCfg_d;
            sampCnt_q   <= sampCnt_d;
            bitIdx_q    <= bitIdx_d;
            bitsLeft_q  <= bitsLeft_d;
            word_q      <= word_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            seqInit_q   <= (state_d == ST_INIT);
            seqSamp_q   <= (state_d == ST_SAMP);
            seqComp_q   <= (state_d == ST_COMP);
            seqUpdate_q <= (state_d == ST_UPDATE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign seq_init     = seqInit_q;
    assign seq_samp     = seqSamp_q;
    assign seq_comp     = seqComp_q;
    assign seq_update   = seqUpdate_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// tb_sar_sequencer
//
// Directed bench for sar_sequencer: reset, full and short conversions,
// sample-time and bit-count edge cases, continuous mode with overrun, and
// abort. Expected values are hand-computed from the conversion timing
// t0 + 2 + S + 2n.

module tb_sar_sequencer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic        cont_mode;
    logic        abort;
    logic [7:0]  cfg_samp_cycles;
    logic [4:0]  cfg_nbits;
    logic        comp_in;
    logic        seq_init;
    logic        seq_samp;
    logic        seq_comp;
    logic        seq_update;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        overrun;
    logic        overrun_clr;

    int testsRun  = 0;
    int failCount = 0;

    sar_sequencer dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .start           (start),
        .cont_mode       (cont_mode),
        .abort           (abort),
        .cfg_samp_cycles (cfg_samp_cycles),
        .cfg_nbits       (cfg_nbits),
        .comp_in         (comp_in),
        .seq_init        (seq_init),
        .seq_samp        (seq_samp),
        .seq_comp        (seq_comp),
        .seq_update      (seq_update),
        .busy            (busy),
        .result          (result),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then feed comp_in from pat (MSB first) on every UPDATE
    // until result_valid rises. cycles counts edges after the start edge.
    task automatic applyStimulus(input logic [15:0] pat, input logic chgCfg,
                                 output int cycles, output int sampCnt,
                                 output int compCnt, output int updCnt);
        cycles  = 0;
        sampCnt = 0;
        compCnt = 0;
        updCnt  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (chgCfg) begin
            cfg_samp_cycles = 8'd200;
            cfg_nbits       = 5'd2;
        end
        while (!result_valid && cycles < 200) begin
            if (seq_samp) sampCnt++;
            if (seq_comp) compCnt++;
            if (seq_update) begin
                int idx;
                idx = 15 - updCnt;
                comp_in = (idx >= 0) ? pat[idx] : 1'b0;
                updCnt++;
            end
            tick();
            cycles++;
        end
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        int cyc, sc, cc, uc, w, c;

        rst_b           = 1'b0;
        start           = 1'b0;
        cont_mode       = 1'b0;
        abort           = 1'b0;
        cfg_samp_cycles = 8'd4;
        cfg_nbits       = 5'd16;
        comp_in         = 1'b0;
        result_ready    = 1'b0;
        overrun_clr     = 1'b0;

        // T1: reset values, then an asynchronous reset in the middle of SAMP.
        #12;
        checkOutput("t1_busy_rst",    32'(busy), 32'd0);
        checkOutput("t1_valid_rst",   32'(result_valid), 32'd0);
        checkOutput("t1_result_rst",  32'(result), 32'd0);
        checkOutput("t1_overrun_rst", 32'(overrun), 32'd0);
        checkOutput("t1_seq_rst",     32'({seq_init, seq_samp, seq_comp, seq_update}), 32'd0);
        rst_b = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t1_init", 32'(seq_init), 32'd1);
        tick();
        tick();
        checkOutput("t1_samp_mid", 32'(seq_samp), 32'd1);
        #3;
        rst_b = 1'b0;
        #1;
        checkOutput("t1_async_busy", 32'(busy), 32'd0);
        checkOutput("t1_async_samp", 32'(seq_samp), 32'd0);
        #2;
        rst_b = 1'b1;
        tick();
        checkOutput("t1_idle_after", 32'({busy, seq_init}), 32'd0);

        // T2: S=4, n=16, pattern 0xA5C3, valid at t0+38.
        cfg_samp_cycles = 8'd4;
        cfg_nbits       = 5'd16;
        applyStimulus(16'hA5C3, 1'b0, cyc, sc, cc, uc);
        checkOutput("t2_latency", 32'(cyc), 32'd38);
        checkOutput("t2_samp",    32'(sc), 32'd4);
        checkOutput("t2_comp",    32'(cc), 32'd16);
        checkOutput("t2_update",  32'(uc), 32'd16);
        checkOutput("t2_result",  32'(result), 32'h0000A5C3);
        checkOutput("t2_busy_done", 32'(busy), 32'd0);
        tick();
        tick();
        tick();
        checkOutput("t2_held_result", 32'(result), 32'h0000A5C3);
        checkOutput("t2_held_valid",  32'(result_valid), 32'd1);
        consume();
        checkOutput("t2_consumed", 32'(result_valid), 32'd0);

        // T3: short conversion, then n=0 and n>NBITS both resolve 16 bits.
        cfg_nbits = 5'd8;
        applyStimulus(16'hFFFF, 1'b0, cyc, sc, cc, uc);
        checkOutput("t3_n8_latency", 32'(cyc), 32'd22);
        checkOutput("t3_n8_update",  32'(uc), 32'd8);
        checkOutput("t3_n8_result",  32'(result), 32'h0000FF00);
        consume();
        cfg_nbits = 5'd0;
        applyStimulus(16'h1234, 1'b0, cyc, sc, cc, uc);
        checkOutput("t3_n0_latency", 32'(cyc), 32'd38);
        checkOutput("t3_n0_result",  32'(result), 32'h00001234);
        consume();
        cfg_nbits = 5'd20;
        applyStimulus(16'h8001, 1'b0, cyc, sc, cc, uc);
        checkOutput("t3_n20_update", 32'(uc), 32'd16);
        checkOutput("t3_n20_result", 32'(result), 32'h00008001);
        consume();

        // T4: S=0 samples for one cycle; config changes mid-conversion ignored.
        cfg_samp_cycles = 8'd0;
        cfg_nbits       = 5'd4;
        applyStimulus(16'hF000, 1'b1, cyc, sc, cc, uc);
        checkOutput("t4_samp",    32'(sc), 32'd1);
        checkOutput("t4_update",  32'(uc), 32'd4);
        checkOutput("t4_latency", 32'(cyc), 32'd11);
        checkOutput("t4_result",  32'(result), 32'h0000F000);
        consume();

        // T5: continuous mode with ready low -> overrun on the second word.
        cfg_samp_cycles = 8'd1;
        cfg_nbits       = 5'd2;
        comp_in         = 1'b1;
        cont_mode       = 1'b1;
        w = 0;
        while (!result_valid && w < 50) begin
            tick();
            w++;
        end
        checkOutput("t5_first_latency", 32'(w), 32'd8);
        checkOutput("t5_first_result",  32'(result), 32'h0000C000);
        checkOutput("t5_no_overrun_yet", 32'(overrun), 32'd0);
        comp_in = 1'b0;
        w = 0;
        while (!overrun && w < 50) begin
            tick();
            w++;
        end
        checkOutput("t5_overrun_latency", 32'(w), 32'd7);
        checkOutput("t5_overrun_result",  32'(result), 32'h00000000);
        checkOutput("t5_overrun_valid",   32'(result_valid), 32'd1);
        overrun_clr = 1'b1;
        cont_mode   = 1'b0;
        comp_in     = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checkOutput("t5_overrun_clr", 32'(overrun), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t5_third_busy", 32'(busy), 32'd1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checkOutput("t5_ready_result",  32'(result), 32'h0000C000);
        checkOutput("t5_ready_valid",   32'(result_valid), 32'd1);
        checkOutput("t5_ready_overrun", 32'(overrun), 32'd0);
        checkOutput("t5_ready_idle",    32'(busy), 32'd0);

        // T6: abort in the fifth COMP leaves the held word untouched.
        cfg_samp_cycles = 8'd2;
        cfg_nbits       = 5'd16;
        comp_in         = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        w = 0;
        while (c < 5 && w < 100) begin
            tick();
            w++;
            if (seq_comp) c++;
        end
        checkOutput("t6_comp5_time", 32'(w), 32'd11);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t6_abort_busy",   32'(busy), 32'd0);
        checkOutput("t6_abort_seq",    32'({seq_init, seq_samp, seq_comp, seq_update}), 32'd0);
        checkOutput("t6_abort_result", 32'(result), 32'h0000C000);
        checkOutput("t6_abort_valid",  32'(result_valid), 32'd1);
        tick();
        checkOutput("t6_stays_idle", 32'(busy), 32'd0);

        // Abort coincident with DONE: no publish, no overrun, no restart.
        cfg_samp_cycles = 8'd1;
        cfg_nbits       = 5'd1;
        cont_mode       = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        cont_mode = 1'b0;
        checkOutput("t6_done_abort_busy",    32'(busy), 32'd0);
        checkOutput("t6_done_abort_result",  32'(result), 32'h0000C000);
        checkOutput("t6_done_abort_valid",   32'(result_valid), 32'd1);
        checkOutput("t6_done_abort_overrun", 32'(overrun), 32'd0);

        // abort held in IDLE blocks start.
        abort = 1'b1;
        start = 1'b1;
        tick();
        checkOutput("t6_idle_abort_blocks", 32'(busy), 32'd0);
        abort = 1'b0;
        start = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
